// File: rtl/write_port_arbiter_pkg.sv
// Package wpa_pkg: destination codes shared by the write-port arbiter and
// users of write_en_decoder. It also holds a helper that classifies a code.
//   DEST_W   : width of a destination code
//   DEST_*   : destination map (0 none, 1 PC, 2 DR, 3..7 R1..R5, 8 TR)
//   DEST_MAX : highest code that names a real register
package wpa_pkg;

    localparam int DEST_W = 4;

    localparam logic [DEST_W-1:0] DEST_NONE = 4'd0;
    localparam logic [DEST_W-1:0] DEST_PC   = 4'd1;
    localparam logic [DEST_W-1:0] DEST_DR   = 4'd2;
    localparam logic [DEST_W-1:0] DEST_R1   = 4'd3;
    localparam logic [DEST_W-1:0] DEST_R2   = 4'd4;
    localparam logic [DEST_W-1:0] DEST_R3   = 4'd5;
    localparam logic [DEST_W-1:0] DEST_R4   = 4'd6;
    localparam logic [DEST_W-1:0] DEST_R5   = 4'd7;
    localparam logic [DEST_W-1:0] DEST_TR   = 4'd8;
    localparam logic [DEST_W-1:0] DEST_MAX  = DEST_TR;

    // True when the code addresses a real register (1..DEST_MAX).
    function automatic logic dest_valid(input logic [DEST_W-1:0] d);
        return (d != DEST_NONE) && (d <= DEST_MAX);
    endfunction

endpackage

// File: rtl/write_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   elig_i    : eligible requesters
//   ptr_i     : index that has first priority this cycle
//   win_oh_o  : one-hot winner
//   win_idx_o : winner index
//   valid_o   : a winner exists
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_oh_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             valid_o
);

    // Two ordered passes: first the indices at or above the pointer, then the
    // ones below it. The first eligible hit in that order wins.
    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        valid_o   = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid_o && elig_i[j] && (j >= int'(ptr_i))) begin
                valid_o     = 1'b1;
                win_oh_o[j] = 1'b1;
                win_idx_o   = IDX_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid_o && elig_i[j] && (j < int'(ptr_i))) begin
                valid_o     = 1'b1;
                win_oh_o[j] = 1'b1;
                win_idx_o   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/write_port_arbiter.sv
// write_port_arbiter: round-robin arbiter for the single register-file write
// port. It picks one requester per cycle and registers the grant, the
// destination code for write_en_decoder and the write data.
//   clk, rst     : clock, synchronous active-high reset
//   req          : per-requester level request
//   dest         : per-requester destination codes, 4 bits each
//   wdata        : per-requester write data, DATA_W bits each
//   hold         : datapath stall, blocks new grants
//   gnt          : registered one-hot grant pulse
//   selection_en : registered destination code, 0 = no write
//   bus_data     : registered write data of the last grant
//   dest_err     : invalid-destination pulse
// Optional feature macro: WPA_DEST_CHECK_EN (destination range check).
//
// Handshake: a requester holds req/dest/wdata stable until it sees its gnt
// bit high. The cycle gnt is high retires the transfer. A requester is
// ineligible while its own grant is visible, so one level request is never
// granted twice.
module write_port_arbiter
    import wpa_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_REQ  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [DEST_W*N_REQ-1:0] dest,
    input  logic [DATA_W*N_REQ-1:0] wdata,
    input  logic                    hold,
    output logic [N_REQ-1:0]        gnt,
    output logic [DEST_W-1:0]       selection_en,
    output logic [DATA_W-1:0]       bus_data,
    output logic                    dest_err
);

    localparam int IDX_W = (N_REQ > 2) ? 2 : 1;

    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [DEST_W-1:0] sel_q, sel_d;
    logic [DATA_W-1:0] bus_q, bus_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  win_oh;
    logic [IDX_W-1:0]  win_idx;
    logic              win_valid;
    logic [DEST_W-1:0] win_dest;
    logic [DATA_W-1:0] win_data;

    assign elig = req & ~gnt_q;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .elig_i    (elig),
        .ptr_i     (ptr_q),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .valid_o   (win_valid)
    );

    // Mux the winner's slices by one-hot select.
    always_comb begin
        win_dest = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_dest = dest[i*DEST_W +: DEST_W];
                win_data = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    logic take;
    assign take = win_valid && !hold;

    always_comb begin
        gnt_d = '0;
        sel_d = DEST_NONE;
        bus_d = bus_q;
        ptr_d = ptr_q;
        if (take) begin
            gnt_d = win_oh;
            bus_d = win_data;
            ptr_d = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
`ifdef WPA_DEST_CHECK_EN
            sel_d = dest_valid(win_dest) ? win_dest : DEST_NONE;
`else
            sel_d = win_dest;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= '0;
            sel_q <= DEST_NONE;
            bus_q <= '0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            sel_q <= sel_d;
            bus_q <= bus_d;
            ptr_q <= ptr_d;
        end
    end

`ifdef WPA_DEST_CHECK_EN
    // The grant still retires the request; only the write is suppressed.
    logic err_q, err_d;
    assign err_d = take && !dest_valid(win_dest);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign dest_err = err_q;
`else
    assign dest_err = 1'b0;
`endif

    assign gnt          = gnt_q;
    assign selection_en = sel_q;
    assign bus_data     = bus_q;

endmodule

// File: tb/tb_write_port_arbiter.sv
module tb_write_port_arbiter;

  localparam int N  = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [4*N-1:0]  dest = '0;
  logic [DW*N-1:0] wdata = '0;
  logic          hold = 1'b0;
  logic [N-1:0]  gnt;
  logic [3:0]    selection_en;
  logic [DW-1:0] bus_data;
  logic          dest_err;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: what the bench believes is visible this cycle
  logic [N-1:0]  m_gnt = '0;
  logic [DW-1:0] m_bus = '0;
  int            m_ptr = 0;
  logic [3:0]    m_sel = '0;
  logic          m_err = 1'b0;

  always #5 clk = ~clk;

  write_port_arbiter #(.DATA_W(DW), .N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .dest(dest), .wdata(wdata), .hold(hold),
    .gnt(gnt), .selection_en(selection_en), .bus_data(bus_data), .dest_err(dest_err)
  );

  // Predict the next cycle from the current inputs, advance one edge, and
  // land 1 time unit after it so outputs can be sampled.
  task automatic tick();
    logic [N-1:0]  e_gnt;
    logic [3:0]    e_sel;
    logic [DW-1:0] e_bus;
    logic          e_err;
    int            e_ptr;
    int            w;
    logic [3:0]    d;
    e_gnt = '0; e_sel = '0; e_bus = m_bus; e_err = 1'b0; e_ptr = m_ptr; w = -1;
    if (rst) begin
      e_bus = '0;
      e_ptr = 0;
    end else if (!hold) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && req[c] && !m_gnt[c]) w = c;
      end
      if (w >= 0) begin
        d = dest[4*w +: 4];
        e_gnt[w] = 1'b1;
        e_bus = wdata[DW*w +: DW];
        e_ptr = (w + 1) % N;
`ifdef WPA_DEST_CHECK_EN
        if (d == 0 || d >= 9) begin
          e_sel = 4'd0;
          e_err = 1'b1;
        end else begin
          e_sel = d;
        end
`else
        e_sel = d;
`endif
      end
    end
    @(posedge clk);
    #1;
    m_gnt = e_gnt; m_sel = e_sel; m_bus = e_bus; m_err = e_err; m_ptr = e_ptr;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; hold = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b111; hold = 1'b0;
    dest = {4'd8, 4'd2, 4'd1};
    wdata = {16'h3333, 16'h2222, 16'h1111};
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (gnt !== 3'b000 || selection_en !== 4'd0 || bus_data !== 16'h0 || dest_err !== 1'b0)
        $display("FAIL reset_hold cyc%0d: gnt=%b sel=%0d bus=%h err=%b, want 000/0/0000/0", i, gnt, selection_en, bus_data, dest_err);
      else n_pass++;
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 3'b001 || selection_en !== 4'd1 || bus_data !== 16'h1111)
      $display("FAIL reset_first_grant: gnt=%b sel=%0d bus=%h, want 001/1/1111", gnt, selection_en, bus_data);
    else n_pass++;
  endtask

  task automatic test_single();
    int last_g;
    do_reset();
    req = 3'b010;
    dest = {4'd0, 4'd4, 4'd0};
    wdata = {16'h0, 16'hBEEF, 16'h0};
    tick();
    n_checks++;
    if (gnt !== 3'b010 || selection_en !== 4'd4 || bus_data !== 16'hBEEF)
      $display("FAIL single_first: gnt=%b sel=%0d bus=%h, want 010/4/beef", gnt, selection_en, bus_data);
    else n_pass++;
    last_g = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (gnt !== m_gnt || selection_en !== m_sel || bus_data !== 16'hBEEF)
        $display("FAIL single_cyc%0d: gnt=%b sel=%0d bus=%h, want %b/%0d/beef", i, gnt, selection_en, bus_data, m_gnt, m_sel);
      else n_pass++;
      n_checks++;
      if (last_g == 1 && gnt[1] === 1'b1)
        $display("FAIL single_consecutive cyc%0d: gnt=%b after a grant, want 000", i, gnt);
      else n_pass++;
      last_g = (gnt[1] === 1'b1) ? 1 : 0;
    end
  endtask

  task automatic test_contention();
    logic [3:0] seq [6];
    seq = '{4'd1, 4'd2, 4'd8, 4'd1, 4'd2, 4'd8};
    do_reset();
    req = 3'b111;
    dest = {4'd8, 4'd2, 4'd1};
    wdata = {16'hC002, 16'hC001, 16'hC000};
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (selection_en !== seq[i] || gnt !== (3'b001 << (i % 3)) || bus_data !== m_bus)
        $display("FAIL contention_cyc%0d: gnt=%b sel=%0d bus=%h, want %b/%0d/%h", i, gnt, selection_en, bus_data, 3'b001 << (i % 3), seq[i], m_bus);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    do_reset();
    req = 3'b111;
    dest = {4'd8, 4'd2, 4'd1};
    wdata = {16'hD002, 16'hD001, 16'hD000};
    tick();
    tick();
    n_checks++;
    if (gnt !== 3'b010)
      $display("FAIL hold_pre: gnt=%b, want 010", gnt);
    else n_pass++;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (gnt !== 3'b000 || selection_en !== 4'd0 || bus_data !== 16'hD001)
        $display("FAIL hold_cyc%0d: gnt=%b sel=%0d bus=%h, want 000/0/d001", i, gnt, selection_en, bus_data);
      else n_pass++;
    end
    hold = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 3'b100 || selection_en !== 4'd8 || bus_data !== 16'hD002)
      $display("FAIL hold_resume: gnt=%b sel=%0d bus=%h, want 100/8/d002", gnt, selection_en, bus_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b111;
    dest = {4'd8, 4'd2, 4'd1};
    wdata = {16'hE002, 16'hE001, 16'hE000};
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 3'b000 || selection_en !== 4'd0 || bus_data !== 16'h0)
      $display("FAIL reset_mid: gnt=%b sel=%0d bus=%h, want 000/0/0000", gnt, selection_en, bus_data);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 3'b001 || selection_en !== 4'd1)
      $display("FAIL reset_mid_ptr: gnt=%b sel=%0d, want 001/1", gnt, selection_en);
    else n_pass++;
  endtask

  task automatic test_dest_check();
    do_reset();
    req = 3'b100;
    dest = {4'd12, 4'd0, 4'd0};
    wdata = {16'hA5A5, 16'h0, 16'h0};
    tick();
    n_checks++;
`ifdef WPA_DEST_CHECK_EN
    if (gnt !== 3'b100 || selection_en !== 4'd0 || dest_err !== 1'b1 || bus_data !== 16'hA5A5)
      $display("FAIL dest_check: gnt=%b sel=%0d err=%b bus=%h, want 100/0/1/a5a5", gnt, selection_en, dest_err, bus_data);
    else n_pass++;
`else
    if (gnt !== 3'b100 || selection_en !== 4'd12 || dest_err !== 1'b0 || bus_data !== 16'hA5A5)
      $display("FAIL dest_check: gnt=%b sel=%0d err=%b bus=%h, want 100/12/0/a5a5", gnt, selection_en, dest_err, bus_data);
    else n_pass++;
`endif
    req = 3'b000;
    tick();
    n_checks++;
    if (gnt !== 3'b000 || dest_err !== 1'b0 || selection_en !== 4'd0)
      $display("FAIL dest_check_after: gnt=%b sel=%0d err=%b, want 000/0/0", gnt, selection_en, dest_err);
    else n_pass++;
  endtask

  task automatic test_random();
    int waitg [N];
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < N; i++) waitg[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Drive: hold pending requests stable, retire or renew granted ones.
      for (int i = 0; i < N; i++) begin
        if (req[i] && m_gnt[i]) begin
          req[i] = ($urandom_range(0, 1) == 1);
          dest[4*i +: 4] = 4'($urandom_range(0, 15));
          wdata[DW*i +: DW] = DW'($urandom);
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          dest[4*i +: 4] = 4'($urandom_range(0, 15));
          wdata[DW*i +: DW] = DW'($urandom);
        end
      end
      hold = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      tick();
      n_checks++;
      if (gnt !== m_gnt || selection_en !== m_sel || bus_data !== m_bus || dest_err !== m_err) begin
        if (errs < 10)
          $display("FAIL random_cyc%0d: gnt=%b sel=%0d bus=%h err=%b, want %b/%0d/%h/%b", cyc, gnt, selection_en, bus_data, dest_err, m_gnt, m_sel, m_bus, m_err);
        errs++;
      end else n_pass++;
      // Starvation: count foreign grants seen while a request stays pending.
      for (int i = 0; i < N; i++) begin
        if (rst || !req[i] || gnt[i]) waitg[i] = 0;
        else if (gnt != '0) waitg[i]++;
      end
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (waitg[i] > N)
          $display("FAIL starvation req%0d: waited %0d grants, want <= %0d", i, waitg[i], N);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_hold();
    test_reset_mid();
    test_dest_check();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/write_port_arbiter.md
# write_port_arbiter

Round-robin arbiter sharing the single register-file write port of the down-sampler datapath among three requesters: ALU writeback, memory load return and PC/sequencer update. Each requester presents a destination code and data. The arbiter grants one requester per cycle and drives the registered 4-bit `selection_en` code into `write_en_decoder`, plus the matching write data onto the shared bus. It sits between the execution units and the register-enable decoder / register bank.

## Interface
- `DATA_W`, 16, width of write data bus
- `N_REQ`, 3, number of requesters (supported range 2..4)

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  N_REQ  per-requester write request, level
- `dest`  in  4*N_REQ  per-requester destination code, slice i = bits [4i+3:4i]
- `wdata`  in  DATA_W*N_REQ  per-requester write data, slice i = bits [DATA_W*i+DATA_W-1:DATA_W*i]
- `hold`  in  1  datapath stall; no new grant while high
- `gnt`  out  N_REQ  one-hot grant pulse, registered
- `selection_en`  out  4  destination code to `write_en_decoder`; 0 = no write
- `bus_data`  out  DATA_W  write data for the granted transfer
- `dest_err`  out  1  invalid-destination pulse (only with `WPA_DEST_CHECK_EN`)

## Operation
- Requester i asserts `req[i]` with `dest` and `wdata` slice i stable. All three stay unchanged until the cycle `gnt[i]` is high.
- Eligible set at each edge: `req[i]` & ~`gnt[i]` (current-cycle value). The requester being granted this cycle is excluded, so a level request is never granted twice for one transfer. Back-to-back transfers from one requester are therefore ≥2 cycles apart.
- If `hold`=0 and the eligible set is non-empty, pick one eligible requester by round robin, starting at `ptr`, where `ptr` is the index after the last granted requester. On the next cycle:
  - `gnt` is one-hot for the winner.
  - `selection_en` = winner's `dest`.
  - `bus_data` = winner's `wdata`.
  - `ptr` = (winner+1) mod N_REQ.
- If `hold`=1 or nothing is eligible: next cycle `gnt`=0, `selection_en`=0, `bus_data` holds its last value, and `ptr` is unchanged.
- A requester may drop `req` at any time before it is granted. A dropped request is simply not granted; this is not an error.
- Reset values: `gnt`=0, `selection_en`=0, `bus_data`=0, `dest_err`=0, `ptr`=0 (requester 0 highest priority first).
- Destination code map: 0 none, 1 PC, 2 DR, 3..7 R1..R5, 8 TR, 9..15 unused.

## Timing
- Latency: `req` sampled at edge N, so `gnt`, `selection_en` and `bus_data` are valid throughout cycle N+1. The register bank writes at edge N+2.
- All outputs come from flops; there is no combinational path from inputs to outputs.
- Sustained throughput: one grant per cycle when ≥2 requesters are active; every 2 cycles for a single requester.
- `hold` asserted at edge N blocks the grant for cycle N+1. A grant already visible in cycle N still completes; it is not revoked.
- Reset at edge N, including mid-transfer: cycle N+1 has all outputs at reset values. A requester whose grant was cleared by reset must re-request.
- Starvation bound: an eligible requester is granted within N_REQ grants.

## Configuration
- Macro: `WPA_DEST_CHECK_EN`.
- Defined: a winner with `dest`=0 or `dest`≥9 still receives `gnt`, which retires the request. In that grant cycle `selection_en`=0 and `dest_err`=1 for exactly that cycle. `bus_data` updates as normal.
- Undefined: `dest` is forwarded unchecked; `write_en_decoder` asserts no enable for invalid codes. `dest_err` is tied to 0.

## Structure
- Package `wpa_pkg` holds:
  - `DEST_W`=4.
  - Destination localparams `DEST_NONE`, `DEST_PC`, `DEST_DR`, `DEST_R1`..`DEST_R5`, `DEST_TR` (0..8), shared with `write_en_decoder` users.
  - `DEST_MAX`=8.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: eligible vector, `ptr`.
  - Outputs: one-hot winner, winner index, valid.
- The top level holds `ptr`, the output flops and the destination check.

## Test plan
- Reset: assert `rst` 2 cycles with all `req`=1 → `gnt`=0, `selection_en`=0, `bus_data`=0 during reset and for the cycle after the deasserting edge. The first grant goes to requester 0.
- Single requester: `req[1]`=1, `dest`=4, `wdata`=16'hBEEF, held → `gnt`=3'b010, `selection_en`=4, `bus_data`=BEEF one cycle after sampling; the next grant comes 2 cycles later, never on consecutive cycles.
- Full contention: all `req`=1 with dests 1/2/8 → grants rotate 0,1,2,0,… each cycle, and `selection_en` sequence is 1,2,8,1.
- Hold: contention as above, `hold`=1 for 3 cycles mid-stream → `gnt`=0 and `selection_en`=0 for those 3 cycles. Rotation resumes at the requester following the last grant.
- Reset mid-operation: `rst` at the edge producing a grant → that cycle shows `gnt`=0 and `ptr` resets, so requester 0 wins next.
- `WPA_DEST_CHECK_EN`: `req[2]` with `dest`=12 → `gnt[2]`=1, `selection_en`=0, `dest_err`=1 for one cycle. Without the macro: `selection_en`=12 and `dest_err`=0.
